rf_write_scheduler: RTL and testbench
=====================================

# rf_write_scheduler

Schedules the single write port of the CPU register file between two requesters: the in-order pipeline writeback and a long-latency return path (loads, multi-cycle units). It also keeps a per-register pending-write scoreboard and stalls issue on RAW/WAW hazards against outstanding long-latency results. It sits between the writeback stage, the long-latency unit and the register file's byte-enabled write port.

## Interface
- DATA_WIDTH, 32, register data width
- ADDR_WIDTH, 5, register address width (32 registers; r0 is hardwired zero)
- LQ_DEPTH, 2, long-latency return queue entries (power of two, ≥2)
- STARVE_LIMIT, 4, cycles the queue head may wait before issue is frozen
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- pw_valid  in  1  pipeline writeback request; always accepted, no ready
- pw_wen  in  4  pipeline byte write enables
- pw_waddr  in  ADDR_WIDTH  pipeline destination register
- pw_wdata  in  DATA_WIDTH  pipeline write data
- lr_valid  in  1  long-latency return request
- lr_ready  out  1  queue can accept a return this cycle
- lr_wen  in  4  return byte write enables
- lr_waddr  in  ADDR_WIDTH  return destination register
- lr_wdata  in  DATA_WIDTH  return data
- iss_valid  in  1  instruction presented at issue
- iss_long  in  1  issuing instruction's result arrives via long-latency path
- iss_waddr  in  ADDR_WIDTH  issuing instruction's destination (0 = none)
- iss_raddr1, iss_raddr2  in  ADDR_WIDTH  issuing instruction's source registers
- stall  out  1  issue must hold this cycle
- rf_wen  out  4  register file byte write enables
- rf_waddr  out  ADDR_WIDTH  register file write address
- rf_wdata  out  DATA_WIDTH  register file write data

## Operation
- Scoreboard: busy[31:1] flops; busy[0] reads as 0 always.
- Issue fires when iss_valid && !stall. On fire with iss_long && iss_waddr≠0, busy[iss_waddr] sets at the edge.
- stall = iss_valid && (busy[iss_raddr1] || busy[iss_raddr2] || busy[iss_waddr] || starve). Any destination write to a busy register stalls (WAW), long or short.
- Return queue: FIFO of {wen, waddr, wdata}, LQ_DEPTH entries. lr_ready = !full (does not look at same-cycle pop). Push on lr_valid && lr_ready.
- Write port priority: pipeline wins. Pipeline is "active" when pw_valid && pw_wen≠0; pw_valid with pw_wen=0 leaves the port free.
- If pipeline active: rf_* = pw_*. Else if queue non-empty: rf_* = head, head pops at the edge, and busy[head.waddr] clears at that edge (waddr 0 clears nothing). Else rf_wen = 0.
- Push and pop in the same cycle are both legal; occupancy is unchanged.
- Starvation: wait counter increments each cycle the queue is non-empty and head not popped; resets to 0 on pop or empty. starve = (counter ≥ STARVE_LIMIT); it stays high until the head pops. Freezing issue lets the pipeline drain, which frees the port.
- rf_* outputs are combinational from pw_* and the queue head.

## Timing
- Reset (rst high at edge): queue empty, counter 0, busy all 0. While rst is high, rf_wen=0, lr_ready=0, stall=0 regardless of inputs.
- Reset mid-operation discards queued returns and pending busy bits. No writes reach the RF in the reset cycle.
- Return latency: a push at edge N is presented on rf_* in cycle N+1 at the earliest. There is no same-cycle bypass from lr_* to rf_*.
- A busy bit clears at the same edge the RF is written. A dependent issue therefore sees stall=0 in the following cycle and reads the new value.
- Full queue: lr_ready=0 the whole cycle, even if a pop occurs. The producer must hold lr_* stable until accepted.
- Issue fire and clear on the same register in the same cycle cannot occur, because a busy destination stalls. Set and clear on different registers proceed independently.

## Test plan
- Reset: pw_valid=1 while rst=1 -> rf_wen=0, lr_ready=0, stall=0. After release, all busy bits read 0.
- Long issue iss_waddr=5, then iss_raddr1=5 -> stall=1. Push lr (waddr=5, wdata=0xDEADBEEF, wen=4'hF) with pipeline idle -> RF write in the next cycle; stall drops the cycle after that write.
- Conflict: pw_valid (waddr=3) and queue head (waddr=7) in the same cycle -> rf_waddr=3; waddr=7 is written the next idle cycle.
- Queue full: two pushes with pipeline continuously active -> lr_ready=0. One idle cycle -> one pop, and lr_ready=1 in the following cycle.
- Starvation: pipeline active every cycle, one queued entry -> stall asserts after 4 waiting cycles. Once the pipeline idles, the entry drains and stall drops.
- pw_valid=1 with pw_wen=0 and a queued entry -> the queue head is written that cycle.

Source files
------------

// File: rtl/rf_write_scheduler.sv
// Register-file write-port arbiter: pipeline writeback has priority over a small FIFO of
// long-latency returns, with a per-register pending-write scoreboard that stalls issue.
module rf_write_scheduler #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 5,
  parameter int unsigned LQ_DEPTH     = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pw_valid,
  input  logic [3:0]            pw_wen,
  input  logic [ADDR_WIDTH-1:0] pw_waddr,
  input  logic [DATA_WIDTH-1:0] pw_wdata,
  input  logic                  lr_valid,
  output logic                  lr_ready,
  input  logic [3:0]            lr_wen,
  input  logic [ADDR_WIDTH-1:0] lr_waddr,
  input  logic [DATA_WIDTH-1:0] lr_wdata,
  input  logic                  iss_valid,
  input  logic                  iss_long,
  input  logic [ADDR_WIDTH-1:0] iss_waddr,
  input  logic [ADDR_WIDTH-1:0] iss_raddr1,
  input  logic [ADDR_WIDTH-1:0] iss_raddr2,
  output logic                  stall,
  output logic [3:0]            rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata
);

  localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;
  localparam int unsigned PtrW    = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int unsigned CntW    = $clog2(LQ_DEPTH + 1);
  localparam int unsigned WaitW   = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [3:0]            wen;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
  } lq_entry_t;

  lq_entry_t             lq_mem_q [LQ_DEPTH];
  lq_entry_t             lq_head;
  lq_entry_t             lq_in;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [WaitW-1:0]      wait_q, wait_d;
  logic [NumRegs-1:0]    busy_q, busy_d;

  logic lq_full, lq_empty;
  logic pw_active, push, pop, fire, starve;

  assign lq_full   = (count_q == CntW'(LQ_DEPTH));
  assign lq_empty  = (count_q == '0);
  assign lq_head   = lq_mem_q[rd_ptr_q];
  assign lq_in     = '{wen: lr_wen, waddr: lr_waddr, wdata: lr_wdata};
  assign pw_active = pw_valid && (pw_wen != 4'h0);
  assign starve    = (wait_q >= WaitW'(STARVE_LIMIT));

  // lr_ready ignores a same-cycle pop so it never depends on the pipeline inputs.
  assign lr_ready = !rst && !lq_full;
  assign push     = lr_valid && lr_ready;
  assign pop      = !rst && !pw_active && !lq_empty;

  // busy_q[0] is held at zero, so r0 never causes a hazard.
  assign stall = !rst && iss_valid &&
                 (busy_q[iss_raddr1] || busy_q[iss_raddr2] || busy_q[iss_waddr] || starve);
  assign fire  = !rst && iss_valid && !stall;

  always_comb begin
    rf_wen   = 4'h0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (rst) begin
      rf_wen = 4'h0;
    end else if (pw_active) begin
      rf_wen   = pw_wen;
      rf_waddr = pw_waddr;
      rf_wdata = pw_wdata;
    end else if (!lq_empty) begin
      rf_wen   = lq_head.wen;
      rf_waddr = lq_head.waddr;
      rf_wdata = lq_head.wdata;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  // Wait counter saturates at the limit; starve then holds until the head drains.
  always_comb begin
    wait_d = wait_q;
    if (lq_empty || pop) begin
      wait_d = '0;
    end else if (!starve) begin
      wait_d = wait_q + WaitW'(1);
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (pop) begin
      busy_d[lq_head.waddr] = 1'b0;
    end
    if (fire && iss_long && (iss_waddr != '0)) begin
      busy_d[iss_waddr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wait_q   <= '0;
      busy_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wait_q   <= wait_d;
      busy_q   <= busy_d;
    end
  end

  // Queue storage needs no reset: occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      lq_mem_q[wr_ptr_q] <= lq_in;
    end
  end

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Randomized bench for rf_write_scheduler against a queue-based reference model.
module tb_rf_write_scheduler;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 5;
  localparam int unsigned LQD = 2;
  localparam int unsigned SL  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          pw_valid;
  logic [3:0]    pw_wen;
  logic [AW-1:0] pw_waddr;
  logic [DW-1:0] pw_wdata;
  logic          lr_valid;
  logic          lr_ready;
  logic [3:0]    lr_wen;
  logic [AW-1:0] lr_waddr;
  logic [DW-1:0] lr_wdata;
  logic          iss_valid;
  logic          iss_long;
  logic [AW-1:0] iss_waddr;
  logic [AW-1:0] iss_raddr1;
  logic [AW-1:0] iss_raddr2;
  logic          stall;
  logic [3:0]    rf_wen;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;

  always #5 clk = ~clk;

  rf_write_scheduler #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .LQ_DEPTH    (LQD),
    .STARVE_LIMIT(SL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pw_valid  (pw_valid),
    .pw_wen    (pw_wen),
    .pw_waddr  (pw_waddr),
    .pw_wdata  (pw_wdata),
    .lr_valid  (lr_valid),
    .lr_ready  (lr_ready),
    .lr_wen    (lr_wen),
    .lr_waddr  (lr_waddr),
    .lr_wdata  (lr_wdata),
    .iss_valid (iss_valid),
    .iss_long  (iss_long),
    .iss_waddr (iss_waddr),
    .iss_raddr1(iss_raddr1),
    .iss_raddr2(iss_raddr2),
    .stall     (stall),
    .rf_wen    (rf_wen),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata)
  );

  typedef struct {
    logic [3:0]    wen;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
  } ret_t;

  // Reference state: returns in flight, registers owed a long result, cycles head has waited.
  ret_t        mq[$];
  bit          mbusy[32];
  int          mwait;
  int unsigned pend[$];
  ret_t        offer;
  bit          offer_v;
  int          n_vec;
  int          n_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic offer_next(input logic [DW-1:0] data);
    if (!offer_v && pend.size() > 0) begin
      offer.waddr = AW'(pend.pop_front());
      offer.wen   = 4'(1 + $urandom_range(0, 14));
      offer.wdata = data;
      offer_v     = 1'b1;
    end
  endtask

  // Applies the current inputs for one cycle, checks outputs mid-cycle, advances the model.
  task automatic step();
    bit            pw_act, pop, push, fire, starve, e_ready, e_stall;
    logic [3:0]    e_wen;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    lr_valid = offer_v;
    lr_wen   = offer.wen;
    lr_waddr = offer.waddr;
    lr_wdata = offer.wdata;
    pw_act  = pw_valid && (pw_wen != 4'h0);
    starve  = (mwait >= SL);
    e_ready = !rst && (mq.size() < LQD);
    e_stall = !rst && iss_valid && (mbusy[iss_raddr1] || mbusy[iss_raddr2] ||
                                    mbusy[iss_waddr] || starve);
    e_wen = 4'h0; e_addr = '0; e_data = '0;
    if (!rst && pw_act) begin
      e_wen = pw_wen; e_addr = pw_waddr; e_data = pw_wdata;
    end else if (!rst && mq.size() > 0) begin
      e_wen = mq[0].wen; e_addr = mq[0].waddr; e_data = mq[0].wdata;
    end
    #4;
    check_eq("lr_ready", 32'(lr_ready), 32'(e_ready));
    check_eq("stall", 32'(stall), 32'(e_stall));
    check_eq("rf_wen", 32'(rf_wen), 32'(e_wen));
    if (e_wen != 4'h0) begin
      check_eq("rf_waddr", 32'(rf_waddr), 32'(e_addr));
      check_eq("rf_wdata", rf_wdata, e_data);
    end
    if (rst) begin
      mq.delete();
      pend.delete();
      foreach (mbusy[i]) mbusy[i] = 1'b0;
      mwait   = 0;
      offer_v = 1'b0;
    end else begin
      pop  = !pw_act && (mq.size() > 0);
      push = lr_valid && e_ready;
      fire = iss_valid && !e_stall;
      if (mq.size() == 0 || pop) mwait = 0;
      else mwait++;
      if (pop) begin
        mbusy[mq[0].waddr] = 1'b0;
        void'(mq.pop_front());
      end
      if (push) begin
        mq.push_back(offer);
        offer_v = 1'b0;
      end
      if (fire && iss_long && iss_waddr != '0) begin
        mbusy[iss_waddr] = 1'b1;
        pend.push_back(int'(iss_waddr));
      end
      mbusy[0] = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pw_valid = 1'b0; pw_wen = 4'h0; pw_waddr = '0; pw_wdata = '0;
    iss_valid = 1'b0; iss_long = 1'b0; iss_waddr = '0; iss_raddr1 = '0; iss_raddr2 = '0;
  endtask

  task automatic pw_drive(input logic [AW-1:0] addr);
    pw_valid = 1'b1; pw_wen = 4'hF; pw_waddr = addr; pw_wdata = $urandom;
  endtask

  task automatic long_issue(input logic [AW-1:0] addr);
    iss_valid = 1'b1; iss_long = 1'b1; iss_waddr = addr; iss_raddr1 = '0; iss_raddr2 = '0;
    step();
    iss_valid = 1'b0; iss_long = 1'b0; iss_waddr = '0;
  endtask

  initial begin
    n_vec = 0; n_err = 0; mwait = 0; offer_v = 1'b0;
    offer = '{wen: 4'h0, waddr: '0, wdata: '0};
    foreach (mbusy[i]) mbusy[i] = 1'b0;
    idle_inputs();
    rst = 1'b1;
    lr_valid = 1'b0; lr_wen = 4'h0; lr_waddr = '0; lr_wdata = '0;
    @(posedge clk); #1;

    // Reset holds outputs quiet even with requests present.
    pw_drive(5'd4); iss_valid = 1'b1; iss_raddr1 = 5'd4;
    step();
    rst = 1'b0;
    idle_inputs();

    // Every register must read not-busy after reset.
    for (int i = 1; i < 32; i++) begin
      iss_valid = 1'b1; iss_raddr1 = AW'(i);
      step();
    end
    idle_inputs();

    // Long result to r5, dependent issue stalls until the return is written.
    long_issue(5'd5);
    iss_valid = 1'b1; iss_raddr1 = 5'd5;
    step();
    offer_next(32'hDEADBEEF);
    for (int i = 0; i < 3; i++) step();
    idle_inputs();

    // Pipeline (r3) beats queued head (r7); r7 drains on the next idle cycle.
    long_issue(5'd7);
    offer_next($urandom);
    pw_drive(5'd3);
    step();
    step();
    idle_inputs();
    step();

    // Fill the queue while the pipeline holds the port, then drain it.
    long_issue(5'd9);
    long_issue(5'd10);
    pw_drive(5'd1);
    offer_next($urandom); step();
    offer_next($urandom); step();
    step();
    idle_inputs();
    step(); step(); step();

    // Starvation: head waits behind an always-active pipeline until issue freezes.
    long_issue(5'd12);
    offer_next($urandom);
    for (int i = 0; i < 8; i++) begin
      pw_drive(AW'(i + 1));
      iss_valid = 1'b1; iss_raddr1 = 5'd1;
      step();
    end
    idle_inputs();
    iss_valid = 1'b1; iss_raddr1 = 5'd1;
    step(); step();
    idle_inputs();

    // Valid writeback with no byte enables leaves the port to the queue.
    long_issue(5'd14);
    offer_next($urandom);
    pw_drive(5'd2); step();
    pw_wen = 4'h0; step();
    idle_inputs(); step();

    // Randomized traffic with alternating light and heavy pipeline load.
    for (int c = 0; c < 4000; c++) begin
      int unsigned pw_pct;
      pw_pct = ((c / 250) % 2 == 0) ? 40 : 92;
      rst = ($urandom_range(0, 299) == 0);
      pw_valid = ($urandom_range(0, 99) < pw_pct);
      pw_wen   = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
      pw_waddr = AW'($urandom);
      pw_wdata = $urandom;
      iss_valid  = $urandom_range(0, 1) == 1;
      iss_long   = $urandom_range(0, 2) == 0;
      iss_waddr  = AW'($urandom);
      iss_raddr1 = AW'($urandom);
      iss_raddr2 = ($urandom_range(0, 1) == 1) ? '0 : AW'($urandom);
      if ($urandom_range(0, 1) == 1) offer_next($urandom);
      step();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
